// File: rtl/opl3_channel_mixer_seq.sv
`default_nettype none
// ============================================================================
// Module   : opl3_channel_mixer_seq
// Brief    : Gathers the serially computed OPL3 channel contributions of one
//            sample period into left/right sums. It tracks channel arrival,
//            saturates the sums and strobes one mixed sample per period.
// Revision : 1.0 - initial release
// ============================================================================
module opl3_channel_mixer_seq #(
  parameter int NUM_CHANNELS = 18,
  parameter int IN_WIDTH     = 13,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sample_clk_en,
  input  logic                              in_valid,
  input  logic [$clog2(NUM_CHANNELS)-1:0]   in_ch,
  input  logic [IN_WIDTH-1:0]               in_sample,
  input  logic                              in_l_en,
  input  logic                              in_r_en,
  output logic                              channel_valid,
  output logic [SAMPLE_WIDTH-1:0]           channel_l,
  output logic [SAMPLE_WIDTH-1:0]           channel_r,
  output logic                              busy,
  output logic                              err_dup,
  output logic                              err_overrun
);

  localparam int CH_W      = $clog2(NUM_CHANNELS);
  // Wide enough that a full period of extreme contributions never wraps.
  localparam int ACC_WIDTH = IN_WIDTH + $clog2(NUM_CHANNELS) + 1;

  localparam logic signed [ACC_WIDTH-1:0] c_sat_max =
    {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_sat_min =
    {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SAT   = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic signed [ACC_WIDTH-1:0]    r_acc_l;
  logic signed [ACC_WIDTH-1:0]    r_acc_r;
  logic [NUM_CHANNELS-1:0]        r_seen;
  logic                           r_restart_pending;
  logic                           r_channel_valid;
  logic [SAMPLE_WIDTH-1:0]        r_channel_l;
  logic [SAMPLE_WIDTH-1:0]        r_channel_r;
  logic                           r_err_dup;
  logic                           r_err_overrun;

  logic [NUM_CHANNELS-1:0]        w_hit;
  logic                           w_ch_ok;
  logic                           w_accept;
  logic [NUM_CHANNELS-1:0]        w_seen_next;
  logic                           w_full;
  logic signed [ACC_WIDTH-1:0]    w_ext;
  logic                           w_clear;
  logic                           w_load_out;
  logic                           w_err_dup;
  logic                           w_err_overrun;
  logic                           w_set_restart;
  logic                           w_restart_val;

  function automatic logic [SAMPLE_WIDTH-1:0] f_sat(input logic signed [ACC_WIDTH-1:0] a);
    if (a > c_sat_max)
      return c_sat_max[SAMPLE_WIDTH-1:0];
    else if (a < c_sat_min)
      return c_sat_min[SAMPLE_WIDTH-1:0];
    else
      return a[SAMPLE_WIDTH-1:0];
  endfunction

  // One-hot decode of in_ch; an out-of-range index decodes to all zeros.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      w_hit[i] = (in_ch == CH_W'(i));
  end

  assign w_ch_ok     = (|w_hit) && !(|(r_seen & w_hit));
  assign w_accept    = (r_state == ST_ACCUM) && in_valid && w_ch_ok;
  assign w_seen_next = r_seen | (w_accept ? w_hit : '0);
  assign w_full      = &w_seen_next;
  assign w_ext       = {{(ACC_WIDTH-IN_WIDTH){in_sample[IN_WIDTH-1]}}, in_sample};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  // Next-state and control decode.
  always_comb begin
    w_next_state  = r_state;
    w_clear       = 1'b0;
    w_load_out    = 1'b0;
    w_err_dup     = 1'b0;
    w_err_overrun = 1'b0;
    w_set_restart = 1'b0;
    w_restart_val = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sample_clk_en) begin
          w_clear      = 1'b1;
          w_next_state = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        w_err_dup = in_valid && !w_ch_ok;
        if (w_full) begin
          // A new period starting together with completion is not an overrun.
          w_next_state  = ST_SAT;
          w_set_restart = 1'b1;
          w_restart_val = sample_clk_en;
        end else if (sample_clk_en) begin
          w_next_state  = ST_SAT;
          w_set_restart = 1'b1;
          w_restart_val = 1'b1;
          w_err_overrun = 1'b1;
        end
      end
      ST_SAT: begin
        w_load_out = 1'b1;
        w_err_dup  = in_valid;
        if (r_restart_pending || sample_clk_en) begin
          w_clear      = 1'b1;
          w_next_state = ST_ACCUM;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Accumulators, arrival mask, output holding registers and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_l           <= '0;
      r_acc_r           <= '0;
      r_seen            <= '0;
      r_restart_pending <= 1'b0;
      r_channel_valid   <= 1'b0;
      r_channel_l       <= '0;
      r_channel_r       <= '0;
      r_err_dup         <= 1'b0;
      r_err_overrun     <= 1'b0;
    end else begin
      r_channel_valid <= w_load_out;
      r_err_dup       <= w_err_dup;
      r_err_overrun   <= w_err_overrun;
      if (w_clear) begin
        r_acc_l <= '0;
        r_acc_r <= '0;
        r_seen  <= '0;
      end else if (w_accept) begin
        r_seen <= w_seen_next;
        if (in_l_en)
          r_acc_l <= r_acc_l + w_ext;
        if (in_r_en)
          r_acc_r <= r_acc_r + w_ext;
      end
      if (w_clear)
        r_restart_pending <= 1'b0;
      else if (w_set_restart)
        r_restart_pending <= w_restart_val;
      if (w_load_out) begin
        r_channel_l <= f_sat(r_acc_l);
        r_channel_r <= f_sat(r_acc_r);
      end
    end
  end

  assign channel_valid = r_channel_valid;
  assign channel_l     = r_channel_l;
  assign channel_r     = r_channel_r;
  assign busy          = (r_state != ST_IDLE);
  assign err_dup       = r_err_dup;
  assign err_overrun   = r_err_overrun;

endmodule
`default_nettype wire
